// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard for in-order issue / out-of-order writeback.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  output logic [AW:0]     pend_cnt,
  output logic            wb_err
);

  // Issue handshake: a reservation of iss_rd is taken on a rising edge where
  // iss_valid and iss_ready are both 1; iss_ready depends only on iss_rd and the
  // stored busy bits, never on iss_valid, so the producer may hold valid freely.

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     pend_q;
  logic [AW:0]     pend_d;
  logic            wb_err_q;

  logic            wb_hit;
  logic            issue_set;
  logic            same_reg;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            err_d;
  logic            fwd1;
  logic            fwd2;

  assign wb_hit    = wr_en && (wr_addr != '0);
  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd];
  assign issue_set = iss_valid && iss_ready && (iss_rd != '0);
  assign same_reg  = issue_set && (iss_rd == wr_addr);

  // An accepted issue always targets a clear bit, so it always adds one.
  assign cnt_inc = issue_set;
  assign cnt_dec = wb_hit && busy_q[wr_addr] && !same_reg;
  assign err_d   = wb_hit && !busy_q[wr_addr] && !same_reg;

  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = pend_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   pend_d = pend_q + {{AW{1'b0}}, 1'b1};
      2'b01:   pend_d = pend_q - {{AW{1'b0}}, 1'b1};
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      pend_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      wb_err_q <= err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_en && (wr_addr == rs1) && (rs1 != '0);
  assign fwd2 = wr_en && (wr_addr == rs2) && (rs2 != '0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Reads are gated by reset so forwarded data cannot leak out while held in reset.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (reset && (rs1 != '0)) begin
      rd1 = fwd1 ? wr_data : regs[rs1];
    end
    if (reset && (rs2 != '0)) begin
      rd2 = fwd2 ? wr_data : regs[rs2];
    end
  end

  assign rs1_busy = reset && !fwd1 && busy_q[rs1];
  assign rs2_busy = reset && !fwd2 && busy_q[rs2];
  assign pend_cnt = pend_q;
  assign wb_err   = wb_err_q;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits (8..64).
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count (power of two, 2..32); AW = log2(NREG).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports rs1 and rs2, input, AW bits each: read addresses.
REQ-006 The block SHALL have ports rd1 and rd2, output, XLEN bits each: read data.
REQ-007 The block SHALL have ports rs1_busy and rs2_busy, output, 1 bit each: a write to the addressed register is pending.
REQ-008 The block SHALL have ports wr_en (input, 1 bit), wr_addr (input, AW bits) and wr_data (input, XLEN bits): the writeback port.
REQ-009 The block SHALL have ports iss_valid (input, 1 bit) and iss_rd (input, AW bits): an issue request reserving a destination register.
REQ-010 The block SHALL have port iss_ready, output, 1 bit: the issue request is accepted this cycle.
REQ-011 The block SHALL have port pend_cnt, output, AW+1 bits: number of registers currently marked busy.
REQ-012 The block SHALL have port wb_err, output, 1 bit: registered one-cycle pulse flagging a writeback to a non-busy register.

Function
REQ-013 Reads SHALL be combinational; register 0 SHALL always read 0 and always report not busy.
REQ-014 A write SHALL occur at the rising clk edge when wr_en=1 and wr_addr!=0; a write to address 0 SHALL be discarded without error.
REQ-015 Scoreboard: one busy bit per register; bit 0 SHALL be tied to 0.
REQ-016 iss_ready SHALL be 1 when iss_rd=0 or busy[iss_rd]=0; otherwise 0 (WAW stall).
REQ-017 An issue handshake (iss_valid and iss_ready both 1, iss_rd!=0) SHALL set busy[iss_rd] at the next edge.
REQ-018 A writeback with wr_addr!=0 SHALL clear busy[wr_addr] at the same edge as the data write.
REQ-019 If an issue and a writeback target the same nonzero register in the same cycle, set SHALL win: busy stays or becomes 1 and the data is written.
REQ-020 pend_cnt SHALL equal the population count of busy bits after each edge, updating by -1, 0 or +1 per cycle. It never exceeds NREG-1 and never wraps.
REQ-021 wb_err SHALL be 1 in the cycle after a writeback to a nonzero register whose busy bit was 0 (same-cycle issue to that register excluded); the data SHALL still be written.
REQ-022 rsN_busy SHALL reflect busy[rsN] combinationally, subject to the bypass rule of REQ-026.

Reset
REQ-023 While reset=0, all registers SHALL be 0, all busy bits 0, pend_cnt=0, wb_err=0, and rd1/rd2=0. Assertion SHALL take effect immediately, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all pending reservations and any in-flight write of that cycle.
REQ-025 After deassertion, the first edge SHALL accept writes and issues normally.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, when wr_en=1 and wr_addr=rsN!=0, rdN SHALL return wr_data and rsN_busy SHALL be 0 in that same cycle.
REQ-027 Without REGFILE_BYPASS_EN, rdN SHALL return the stored value and rsN_busy the stored busy bit until the edge (no forwarding).

Verification
REQ-028 Reset then read every address: all rd1/rd2=0, rs*_busy=0, pend_cnt=0.
REQ-029 Issue rd=5, then issue rd=5 again: iss_ready=0 on the second issue and pend_cnt=1. Writeback x5=0xDEADBEEF gives pend_cnt=0 and rd1(rs1=5)=0xDEADBEEF.
REQ-030 Writeback x7=0x12 with wr_en and rs1=7 in the same cycle: with REGFILE_BYPASS_EN, rd1=0x12 that cycle; without it, rd1=old value that cycle and 0x12 next cycle.
REQ-031 Writeback x3 with no prior issue gives wb_err=1 for exactly one cycle and x3 updated. Issue+writeback x9 in the same cycle gives busy[9]=1, wb_err=0 and pend_cnt+1.
REQ-032 Issue x1..x4 (pend_cnt=4), then assert reset asynchronously between edges: pend_cnt=0 and all busy=0 immediately. Writes to x0 are ignored and x0 reads 0.
